// File: rtl/program_memory_unit.sv
// rtl/program_memory_unit.sv - program/data memory with host loader, load/run FSM and run statistics
// Combinational read, synchronous write; the host streams a program in, then the core is released.

module program_memory_unit #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic              load_ready,
  input  logic              host_halt,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_write,
  input  logic [DATA_W-1:0] mem_write_data,
  output logic [DATA_W-1:0] mem_read_data,
  output logic              start_execution,
  output logic [ADDR_W:0]   loaded_words,
  output logic [15:0]       cycle_count,
  output logic              write_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    ARM  = 2'd2,
    RUN  = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);
  localparam logic [ADDR_W:0]   WORD_ONE  = (ADDR_W + 1)'(1);

  state_t            state;
  state_t            next_state;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] pointer;
  logic              load_we;
  logic              core_we;
  logic              at_end;
  logic              load_accept;

  assign load_ready    = (state == LOAD);
  // Halt wins over a simultaneous beat: that word is dropped, not written.
  assign load_we       = load_valid && load_ready && !host_halt;
  assign core_we       = (state == RUN) && mem_write;
  assign at_end        = (pointer == LAST_ADDR);
  assign load_accept   = (state == IDLE) && load_start;
  assign mem_read_data = mem[mem_addr];

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (load_start) next_state = LOAD;
      LOAD: begin
        if (host_halt) begin
          next_state = IDLE;
        end else if (load_we && (load_last || at_end)) begin
          next_state = ARM;
        end
      end
      ARM:  next_state = RUN;
      RUN:  if (host_halt) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      start_execution <= 1'b0;
      pointer         <= '0;
      loaded_words    <= '0;
      cycle_count     <= '0;
      write_err       <= 1'b0;
    end else begin
      state           <= next_state;
      // Registered so the core enable rises the cycle after ARM and falls the cycle after halt.
      start_execution <= (next_state == RUN);

      if (load_accept) begin
        pointer      <= '0;
        loaded_words <= '0;
      end else if (load_we) begin
        pointer      <= at_end ? pointer : pointer + PTR_ONE;
        loaded_words <= loaded_words + WORD_ONE;
      end

      if (state == ARM) begin
        cycle_count <= '0;
      end else if ((state == RUN) && (cycle_count != 16'hFFFF)) begin
        cycle_count <= cycle_count + 16'd1;
      end

      if (mem_write && (state != RUN)) begin
        write_err <= 1'b1;
      end else if (load_accept) begin
        write_err <= 1'b0;
      end
    end
  end

  // Loader and core never write together: the loader only writes in LOAD, the core only in RUN.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (load_we) begin
      mem[pointer] <= load_data;
    end else if (core_we) begin
      mem[mem_addr] <= mem_write_data;
    end
  end

endmodule

// File: tb/tb_program_memory_unit.sv
// tb/tb_program_memory_unit.sv - directed self-checking bench for program_memory_unit
// Inputs change just after the falling edge; outputs are checked before the next rising edge.

module tb_program_memory_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        load_start;
  logic        load_valid;
  logic [15:0] load_data;
  logic        load_last;
  logic        load_ready;
  logic        host_halt;
  logic [4:0]  mem_addr;
  logic        mem_write;
  logic [15:0] mem_write_data;
  logic [15:0] mem_read_data;
  logic        start_execution;
  logic [5:0]  loaded_words;
  logic [15:0] cycle_count;
  logic        write_err;

  int n_cmp = 0;
  int n_bad = 0;

  program_memory_unit #(.DATA_W(16), .ADDR_W(5), .DEPTH(32)) dut (
    .clock(clock),
    .reset(reset),
    .load_start(load_start),
    .load_valid(load_valid),
    .load_data(load_data),
    .load_last(load_last),
    .load_ready(load_ready),
    .host_halt(host_halt),
    .mem_addr(mem_addr),
    .mem_write(mem_write),
    .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data),
    .start_execution(start_execution),
    .loaded_words(loaded_words),
    .cycle_count(cycle_count),
    .write_err(write_err)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] observed, input logic [31:0] expected);
    n_cmp++;
    assert (observed === expected) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", name, observed, expected);
    end
  endtask

  task automatic cyc();
    @(negedge clock);
  endtask

  task automatic read_check(input string name, input logic [4:0] addr, input logic [15:0] expected);
    mem_addr = addr;
    #1;
    check(name, 32'(mem_read_data), 32'(expected));
  endtask

  task automatic beat(input logic [15:0] data, input logic last);
    load_valid = 1'b1;
    load_data  = data;
    load_last  = last;
    cyc();
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  initial begin
    reset          = 1'b1;
    load_start     = 1'b0;
    load_valid     = 1'b0;
    load_data      = 16'h0;
    load_last      = 1'b0;
    host_halt      = 1'b0;
    mem_addr       = 5'd0;
    mem_write      = 1'b0;
    mem_write_data = 16'h0;

    // Reset state
    #3;
    check("rst_load_ready", 32'(load_ready), 32'd0);
    check("rst_start_exec", 32'(start_execution), 32'd0);
    check("rst_loaded_words", 32'(loaded_words), 32'd0);
    check("rst_cycle_count", 32'(cycle_count), 32'd0);
    check("rst_write_err", 32'(write_err), 32'd0);
    for (int a = 0; a < 32; a++) read_check("rst_mem", 5'(a), 16'h0000);
    cyc();
    reset = 1'b0;
    cyc();
    check("idle_load_ready", 32'(load_ready), 32'd0);

    // Normal 3-word load and run
    load_start = 1'b1;
    cyc();
    load_start = 1'b0;
    check("load_ready_in_load", 32'(load_ready), 32'd1);
    beat(16'h8801, 1'b0);
    beat(16'h8902, 1'b0);
    beat(16'h3820, 1'b1);
    check("arm_load_ready", 32'(load_ready), 32'd0);
    check("arm_start_exec", 32'(start_execution), 32'd0);
    check("arm_loaded_words", 32'(loaded_words), 32'd3);
    cyc();
    check("run_start_exec", 32'(start_execution), 32'd1);
    check("run_cycle_count0", 32'(cycle_count), 32'd0);
    read_check("rd_w0", 5'd0, 16'h8801);
    cyc();
    read_check("rd_w1", 5'd1, 16'h8902);
    cyc();
    read_check("rd_w2", 5'd2, 16'h3820);
    cyc();
    read_check("rd_w3", 5'd3, 16'h0000);
    cyc();
    check("run_cycle_count4", 32'(cycle_count), 32'd4);

    // Core write in RUN: old value before the edge, new value after
    mem_addr       = 5'd20;
    mem_write      = 1'b1;
    mem_write_data = 16'h1234;
    #1;
    check("rdw_old", 32'(mem_read_data), 32'h0000);
    cyc();
    mem_write = 1'b0;
    #1;
    check("rdw_new", 32'(mem_read_data), 32'h1234);

    // Halt, then a core write outside RUN
    host_halt = 1'b1;
    cyc();
    host_halt = 1'b0;
    check("halt_start_exec", 32'(start_execution), 32'd0);
    mem_addr       = 5'd21;
    mem_write      = 1'b1;
    mem_write_data = 16'h5555;
    cyc();
    mem_write = 1'b0;
    check("werr_set", 32'(write_err), 32'd1);
    read_check("werr_no_write", 5'd21, 16'h0000);
    read_check("retained_20", 5'd20, 16'h1234);

    // Full-depth load without load_last; load_start clears write_err
    cyc();
    load_start = 1'b1;
    cyc();
    load_start = 1'b0;
    check("werr_cleared", 32'(write_err), 32'd0);
    for (int i = 0; i < 31; i++) beat(16'(16'h0100 + i), 1'b0);
    check("full_31_ready", 32'(load_ready), 32'd1);
    check("full_31_words", 32'(loaded_words), 32'd31);
    beat(16'h011F, 1'b0);
    check("full_arm_ready", 32'(load_ready), 32'd0);
    check("full_words", 32'(loaded_words), 32'd32);
    cyc();
    check("full_start_exec", 32'(start_execution), 32'd1);
    read_check("full_mem31", 5'd31, 16'h011F);
    read_check("full_mem0", 5'd0, 16'h0100);
    host_halt = 1'b1;
    cyc();
    host_halt = 1'b0;

    // Backpressure and abort with a dropped simultaneous beat
    load_start = 1'b1;
    cyc();
    load_start = 1'b0;
    beat(16'hAAA0, 1'b0);
    beat(16'hAAA1, 1'b0);
    repeat (5) cyc();
    check("stall_ready", 32'(load_ready), 32'd1);
    check("stall_words", 32'(loaded_words), 32'd2);
    host_halt  = 1'b1;
    load_valid = 1'b1;
    load_data  = 16'hBEEF;
    cyc();
    host_halt  = 1'b0;
    load_valid = 1'b0;
    check("abort_ready", 32'(load_ready), 32'd0);
    check("abort_words", 32'(loaded_words), 32'd2);
    read_check("abort_mem2", 5'd2, 16'h0102);
    read_check("abort_mem1", 5'd1, 16'hAAA1);
    cyc();
    cyc();
    check("abort_start_exec", 32'(start_execution), 32'd0);
    check("abort_idle_ready", 32'(load_ready), 32'd0);

    // Reload, run to saturation, then asynchronous reset mid-run
    load_start = 1'b1;
    cyc();
    load_start = 1'b0;
    beat(16'h8801, 1'b0);
    beat(16'h8902, 1'b0);
    beat(16'h3820, 1'b1);
    cyc();
    check("sat_start_exec", 32'(start_execution), 32'd1);
    repeat (70000) cyc();
    check("sat_cycle_count", 32'(cycle_count), 32'hFFFF);
    read_check("pre_rst_mem0", 5'd0, 16'h8801);
    cyc();
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_start_exec", 32'(start_execution), 32'd0);
    check("mid_rst_cycle_count", 32'(cycle_count), 32'd0);
    check("mid_rst_words", 32'(loaded_words), 32'd0);
    read_check("mid_rst_mem0", 5'd0, 16'h0000);
    read_check("mid_rst_mem1", 5'd1, 16'h0000);
    read_check("mid_rst_mem2", 5'd2, 16'h0000);
    cyc();
    reset = 1'b0;
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
